// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and
// the baud tick divider used by both the receiver and the matching transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Clocks per oversample tick; integer division truncates toward zero.
    function automatic int tick_div(input int clock_freq, input int baud_rate,
                                    input int oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every TICK_DIV clocks, with a
// restart input that re-phases the divider to a detected start edge.
module uart_baud_tick #(
    parameter int CLOCK_FREQ = 48_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    import uart_pkg::*;

    localparam int TICK_DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CNT_LAST) && !restart;

endmodule

// File: rtl/uart_rx_fifo_less_v2.sv
// Parametrised UART receiver: synchronised, majority-voted oversampled RX with
// a single-word valid/ready output and parity, framing and overrun reporting.
module uart_rx_fifo_less_v2 #(
    parameter int CLOCK_FREQ = 48_000_000,
    parameter int BAUD_RATE  = 9_600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun
);
    import uart_pkg::*;

    localparam int TICK_DIV = tick_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_C    = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_INV   = (PARITY == PARITY_ODD);

    if (TICK_DIV < 1) begin : g_chk_div
        $error("CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("STOP_BITS must be 1 or 2");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_chk_par
        $error("PARITY must be 0, 1 or 2");
    end

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    logic                 restart;
    logic                 tick;
    logic                 wrap;
    logic [SW-1:0]        sample_cnt;
    logic [2:0]           samples;
    logic                 maj;
    logic                 frame_bad;
    logic                 handshake;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 stop_bad;
    logic                 parity_bad;
    logic [DATA_BITS-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // The divider and sample counter re-phase on the start edge so samples land mid-bit.
    assign restart = (state == IDLE) && !rx_s;

    uart_baud_tick #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    assign wrap      = tick && (sample_cnt == S_LAST);
    assign maj       = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);
    assign frame_bad = stop_bad | ~maj;
    assign handshake = data_valid && data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
            samples    <= '0;
        end else if (restart) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + SW'(1);
            if (sample_cnt == S_A || sample_cnt == S_B || sample_cnt == S_C) begin
                samples <= {samples[1:0], rx_s};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            stop_bad     <= 1'b0;
            parity_bad   <= 1'b0;
            shift_reg    <= '0;
        end else begin
            if (handshake) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (wrap) begin
                        if (!maj) begin
                            state      <= DATA;
                            bit_cnt    <= '0;
                            stop_cnt   <= 1'b0;
                            stop_bad   <= 1'b0;
                            parity_bad <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (wrap) begin
                        shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            state <= (PARITY != PARITY_NONE) ? uart_pkg::PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                uart_pkg::PARITY: begin
                    if (wrap) begin
                        parity_bad <= (maj != (^shift_reg ^ PAR_INV));
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        if (stop_cnt == STOP_LAST) begin
                            // A word still waiting for the consumer wins over the new frame.
                            if (!data_valid || handshake) begin
                                data_out     <= shift_reg;
                                parity_error <= parity_bad;
                                frame_error  <= frame_bad;
                                data_valid   <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            state <= frame_bad ? WAIT_HIGH : IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                            stop_bad <= stop_bad | ~maj;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo_less_v2.sv
// Bench for uart_rx_fifo_less_v2: 8N1, 8E1, 8O1 and 8N2 receivers at 1 Mbaud
// from 48 MHz (48 clocks per bit), checked against a frame-level model.
module tb_uart_rx_fifo_less_v2;
    import uart_pkg::*;

    localparam int NI       = 4;
    localparam int BIT_CLKS = 48;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx   [NI];
    logic       rdy  [NI];
    logic [7:0] dout [NI];
    logic       dv   [NI];
    logic       perr [NI];
    logic       ferr [NI];
    logic       ovr  [NI];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_rx_fifo_less_v2 #(
            .CLOCK_FREQ(48_000_000),
            .BAUD_RATE (1_000_000),
            .OVERSAMPLE(16),
            .DATA_BITS (8),
            .PARITY    (g == 1 ? 1 : (g == 2 ? 2 : 0)),
            .STOP_BITS (g == 3 ? 2 : 1)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .rx          (rx[g]),
            .data_out    (dout[g]),
            .data_valid  (dv[g]),
            .data_ready  (rdy[g]),
            .parity_error(perr[g]),
            .frame_error (ferr[g]),
            .overrun     (ovr[g])
        );
    end

    function automatic int par_of(input int i);
        return (i == 1) ? PARITY_EVEN : ((i == 2) ? PARITY_ODD : PARITY_NONE);
    endfunction

    function automatic int stops_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int nbits(input int i);
        return 1 + 8 + ((par_of(i) != PARITY_NONE) ? 1 : 0) + stops_of(i);
    endfunction

    // Scoreboard entry: {data[7:0], parity_error, frame_error}
    logic [9:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         words[NI];
    int         sel = 0;
    int         t_start = 0;
    logic       lat_en = 1'b0;
    logic       hs_prev = 1'b0;
    logic       dv_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor on the selected receiver: every handshake pops the model queue.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!reset) begin
            if (hs_prev) check("dv_clear", 32'(dv[sel]), 0);
            if (lat_en && dv[sel] && !dv_prev)
                check("latency", 32'(cyc - t_start), 32'(3 + BIT_CLKS * nbits(sel)));
            hs_prev = 1'b0;
            if (dv[sel] && rdy[sel]) begin
                words[sel]++;
                hs_prev = 1'b1;
                check("exp_avail", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data", 32'(dout[sel]), 32'(e[9:2]));
                    check("parity_error", 32'(perr[sel]), 32'(e[1]));
                    check("frame_error", 32'(ferr[sel]), 32'(e[0]));
                end
            end
        end
        dv_prev = dv[sel];
    end

    // Drives one frame on receiver i and records its expected outcome.
    task automatic send_frame(input int i, input logic [7:0] d, input logic bad_par,
                              input logic [1:0] stop_v, input int glitch_bit);
        logic [11:0] bits;
        int          n;
        logic        ep;
        logic        pbit;
        logic        perr_e;
        logic        ferr_e;
        bits   = '0;
        n      = 0;
        bits[n] = 1'b0;
        n++;
        for (int k = 0; k < 8; k++) begin
            bits[n] = d[k];
            n++;
        end
        ep     = (^d) ^ (par_of(i) == PARITY_ODD);
        pbit   = bad_par ? ~ep : ep;
        perr_e = 1'b0;
        if (par_of(i) != PARITY_NONE) begin
            bits[n] = pbit;
            n++;
            perr_e = (pbit != ep);
        end
        ferr_e = 1'b0;
        for (int s = 0; s < stops_of(i); s++) begin
            bits[n] = stop_v[s];
            n++;
            if (!stop_v[s]) ferr_e = 1'b1;
        end
        exp_q.push_back({d, perr_e, ferr_e});
        t_start = cyc;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                rx[i] = (b == glitch_bit && c == 27) ? ~bits[b] : bits[b];
                tick_n(1);
            end
        end
        rx[i] = 1'b1;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int       w0;
        int       ii;
        logic [7:0] rd;
        logic       rbad;
        logic [1:0] rstop;
        int       rgl;
        logic     rmode;
        for (int i = 0; i < NI; i++) begin
            rx[i]    = 1'b1;
            rdy[i]   = 1'b1;
            words[i] = 0;
        end
        reset = 1'b1;
        tick_n(4);
        for (int i = 0; i < NI; i++) begin
            check("rst_valid", 32'(dv[i]), 0);
            check("rst_data", 32'(dout[i]), 0);
            check("rst_flags", {29'd0, perr[i], ferr[i], ovr[i]}, 0);
        end
        reset = 1'b0;
        tick_n(5);

        // 8N1 0xA5 with data_ready held high
        sel = 0;
        lat_en = 1'b1;
        send_frame(0, 8'hA5, 1'b0, 2'b11, -1);
        tick_n(10);
        check("a5_drained", 32'(exp_q.size()), 0);

        // 8E1 / 8O1 parity, 0x03
        sel = 1;
        send_frame(1, 8'h03, 1'b1, 2'b11, -1);
        tick_n(10);
        send_frame(1, 8'h03, 1'b0, 2'b11, -1);
        tick_n(10);
        sel = 2;
        send_frame(2, 8'h03, 1'b0, 2'b11, -1);
        tick_n(10);
        send_frame(2, 8'h03, 1'b1, 2'b11, -1);
        tick_n(10);
        check("par_drained", 32'(exp_q.size()), 0);

        // Short low pulse is a false start
        sel = 0;
        w0 = words[0];
        rx[0] = 1'b0;
        tick_n(10);
        rx[0] = 1'b1;
        tick_n(100);
        check("glitch_words", 32'(words[0] - w0), 0);
        check("glitch_valid", 32'(dv[0]), 0);
        check("glitch_idle", 32'(g_dut[0].u_dut.state == IDLE), 1);
        send_frame(0, 8'h3C, 1'b0, 2'b11, 3);
        tick_n(10);

        // 8N2 with second stop low, then a two-frame break
        sel = 3;
        send_frame(3, 8'h96, 1'b0, 2'b01, -1);
        tick_n(10);
        w0 = words[3];
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        t_start = cyc;
        rx[3] = 1'b0;
        tick_n(2 * nbits(3) * BIT_CLKS);
        check("break_words", 32'(words[3] - w0), 1);
        check("break_wait", 32'(g_dut[3].u_dut.state == WAIT_HIGH), 1);
        rx[3] = 1'b1;
        tick_n(60);
        check("break_after", 32'(words[3] - w0), 1);
        check("break_idle", 32'(g_dut[3].u_dut.state == IDLE), 1);

        // Overrun: two back-to-back frames with the consumer stalled
        sel = 0;
        lat_en = 1'b0;
        rdy[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 2'b11, -1);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1);
        void'(exp_q.pop_back());  // the second frame is the one dropped
        tick_n(10);
        check("ovr_data", 32'(dout[0]), 32'h11);
        check("ovr_valid", 32'(dv[0]), 1);
        check("ovr_flag", 32'(ovr[0]), 1);
        rdy[0] = 1'b1;
        tick_n(1);
        rdy[0] = 1'b0;
        check("ovr_hs_valid", 32'(dv[0]), 0);
        check("ovr_hs_flag", 32'(ovr[0]), 0);
        tick_n(5);

        // Reset during the 4th data bit, with a stale word pending
        lat_en = 1'b1;
        send_frame(0, 8'hFF, 1'b0, 2'b11, -1);
        void'(exp_q.pop_back());  // discarded by the reset below
        tick_n(10);
        check("pre_rst_valid", 32'(dv[0]), 1);
        rd = 8'h5A;
        for (int c = 0; c < 4 * BIT_CLKS + 20; c++) begin
            rx[0] = (c < BIT_CLKS) ? 1'b0 : rd[c / BIT_CLKS - 1];
            tick_n(1);
        end
        reset = 1'b1;
        tick_n(1);
        check("mid_rst_valid", 32'(dv[0]), 0);
        check("mid_rst_data", 32'(dout[0]), 0);
        check("mid_rst_flags", {29'd0, perr[0], ferr[0], ovr[0]}, 0);
        check("mid_rst_idle", 32'(g_dut[0].u_dut.state == IDLE), 1);
        reset = 1'b0;
        rx[0] = 1'b1;
        tick_n(10);
        rdy[0] = 1'b1;
        send_frame(0, 8'h5A, 1'b0, 2'b11, -1);
        tick_n(10);
        check("post_rst_drained", 32'(exp_q.size()), 0);

        // Randomized frames across all four formats
        for (int f = 0; f < 24; f++) begin
            ii    = $urandom_range(0, NI - 1);
            rd    = 8'($urandom);
            rbad  = ($urandom_range(0, 3) == 0);
            rstop = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            rgl   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1;
            rmode = 1'($urandom_range(0, 1));
            sel = ii;
            rdy[ii] = rmode;
            send_frame(ii, rd, rbad, rstop, rgl);
            if (!rmode) begin
                tick_n($urandom_range(10, 40));
                check("rand_held", 32'(dv[ii]), 1);
                check("rand_no_ovr", 32'(ovr[ii]), 0);
                rdy[ii] = 1'b1;
                tick_n(1);
            end
            tick_n(10);
            check("rand_drained", 32'(exp_q.size()), 0);
        end

        tick_n(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
